// File: rtl/log_conv_pipe_pkg.sv
// Shared log-domain constants, characteristic-width helper and result bundle.
// Optional ceil(log2) field is present when LOGCONV_CEIL_EN is defined.
package log_pkg;

    localparam int LOG_W_DEF    = 8;
    localparam int LOG_FRAC_DEF = 4;

    function automatic int log_cw(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int LOG_CW_DEF = log_cw(LOG_W_DEF);

    typedef struct packed {
        logic [LOG_CW_DEF-1:0]   k;
        logic [LOG_FRAC_DEF-1:0] f;
        logic                    z;
`ifdef LOGCONV_CEIL_EN
        logic [LOG_CW_DEF:0]     c;
`endif
    } log_res_t;

endpackage

// File: rtl/log_conv_pipe_if.sv
// Operand/result handshake bundle for the log converter pipeline.
// out_ca/out_cb exist only when LOGCONV_CEIL_EN is defined.
interface log_conv_pipe_if import log_pkg::*; #(
    parameter int W    = LOG_W_DEF,
    parameter int FRAC = LOG_FRAC_DEF
);
    localparam int CW = log_cw(W);

    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   out_ka;
    logic [CW-1:0]   out_kb;
    logic [FRAC-1:0] out_fa;
    logic [FRAC-1:0] out_fb;
    logic            out_za;
    logic            out_zb;
`ifdef LOGCONV_CEIL_EN
    logic [CW:0]     out_ca;
    logic [CW:0]     out_cb;
`endif

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_ka, out_kb, out_fa, out_fb, out_za, out_zb
`ifdef LOGCONV_CEIL_EN
        , input out_ca, out_cb
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_ka, out_kb, out_fa, out_fb, out_za, out_zb
`ifdef LOGCONV_CEIL_EN
        , output out_ca, out_cb
`endif
    );

endinterface

// File: rtl/log_conv_pipe_lead_one_det.sv
// Combinational leading-one detector; zero_o flags an all-zero input.
module lead_one_det import log_pkg::*; #(
    parameter int W = LOG_W_DEF,
    localparam int CW = log_cw(W)
) (
    input  logic [W-1:0]  x_i,
    output logic [CW-1:0] pos_o,
    output logic          zero_o
);

    always_comb begin
        pos_o  = '0;
        zero_o = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (x_i[i]) begin
                pos_o  = i[CW-1:0];
                zero_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/log_conv_pipe.sv
// Two-stage valid/ready dual-operand Mitchell log converter (k, f, z per operand).
// Defining LOGCONV_CEIL_EN adds the registered ceil(log2 x) outputs out_ca/out_cb.
module log_conv_pipe import log_pkg::*; #(
    parameter int W    = LOG_W_DEF,
    parameter int FRAC = LOG_FRAC_DEF
) (
    input  logic           clk,
    input  logic           rst,
    log_conv_pipe_if.slave io
);

    localparam int CW = log_cw(W);

    typedef struct packed {
        logic [W-1:0]  x;
        logic [CW-1:0] k;
        logic          z;
    } opnd_t;

    typedef struct packed {
        logic [CW-1:0]   k;
        logic [FRAC-1:0] f;
        logic            z;
`ifdef LOGCONV_CEIL_EN
        logic [CW:0]     c;
`endif
    } res_t;

    // Normalising x so its leading one sits at the top of a W+FRAC wide window
    // leaves the fraction directly below it, zero-filled when FRAC exceeds k.
    function automatic res_t convert(input opnd_t op);
        logic [CW-1:0] shamt;
        res_t          r;
`ifdef LOGCONV_CEIL_EN
        logic [W+FRAC-1:0] ext;
`endif
        shamt = CW'(W - 1) - op.k;
        r     = '0;
        r.k   = op.k;
        r.z   = op.z;
        r.f   = FRAC'(({op.x, {FRAC{1'b0}}} << shamt) >> (W - 1));
`ifdef LOGCONV_CEIL_EN
        ext   = {op.x, {FRAC{1'b0}}} << shamt;
        r.c   = {1'b0, op.k} + {{CW{1'b0}}, (ext[W+FRAC-2:0] != '0)};
`endif
        return r;
    endfunction

    logic          s1_valid_q, s1_valid_d;
    opnd_t         s1_a_q, s1_a_d;
    opnd_t         s1_b_q, s1_b_d;
    logic          s2_valid_q, s2_valid_d;
    res_t          s2_a_q, s2_a_d;
    res_t          s2_b_q, s2_b_d;
    logic          s1_adv, s2_adv;
    logic [CW-1:0] ka, kb;
    logic          za, zb;

    lead_one_det #(.W(W)) u_lod_a (.x_i(io.in_a), .pos_o(ka), .zero_o(za));
    lead_one_det #(.W(W)) u_lod_b (.x_i(io.in_b), .pos_o(kb), .zero_o(zb));

    assign s2_adv = io.out_ready || !s2_valid_q;
    assign s1_adv = s2_adv || !s1_valid_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_a_d     = s2_a_q;
        s2_b_d     = s2_b_q;
        if (s1_adv) begin
            s1_valid_d = io.in_valid;
            if (io.in_valid) begin
                s1_a_d = '{x: io.in_a, k: ka, z: za};
                s1_b_d = '{x: io.in_b, k: kb, z: zb};
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_a_d = convert(s1_a_q);
                s2_b_d = convert(s1_b_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_a_q     <= '0;
            s2_b_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_a_q     <= s2_a_d;
            s2_b_q     <= s2_b_d;
        end
    end

    assign io.in_ready  = s1_adv;
    assign io.out_valid = s2_valid_q;
    assign io.out_ka    = s2_a_q.k;
    assign io.out_kb    = s2_b_q.k;
    assign io.out_fa    = s2_a_q.f;
    assign io.out_fb    = s2_b_q.f;
    assign io.out_za    = s2_a_q.z;
    assign io.out_zb    = s2_b_q.z;
`ifdef LOGCONV_CEIL_EN
    assign io.out_ca    = s2_a_q.c;
    assign io.out_cb    = s2_b_q.c;
`endif

endmodule
